buf_xfer_engine: RTL
====================

Name: buf_xfer_engine

Overview:
- DMA-style engine that moves words between external memory and the on-chip activation/weight buffer.
- Sits directly downstream of the register file. It consumes the general__mem_load_* / general__mem_save_* fields and the start_loading_buffer / start_saving_buffer / abrupt_end write strobes.
- It produces the general__buffer_loaded and general__buffer_saved status bits.
- The top level concatenates the upper/lower register halves into the 32-bit address and word-count inputs.

Parameters:
DATA_W, 16, data word width (memory and buffer)
BUF_AW, 16, buffer address width
MAX_OUTST, 4, maximum outstanding memory read requests (power of 2, 1..16)
ADDR_INC, 1, external memory address increment per word

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
start_load  in  1  single-cycle strobe (general__start_loading_buffer_wr_en)
start_save  in  1  single-cycle strobe (general__start_saving_buffer_wr_en)
abort  in  1  single-cycle strobe (general__abrupt_end_wr_en)
load_mem_start  in  32  {mem_load_start_upper, lower}
load_words  in  32  {mem_load_words_upper, lower}
load_buf_addr  in  16  first buffer address for load (low BUF_AW bits used)
save_mem_start  in  32  {mem_save_start_upper, lower}
save_words  in  32  {mem_save_words_upper, lower}
save_buf_addr  in  16  first buffer address for save
mem_rd_valid  out  1  read request valid
mem_rd_ready  in  1  read request accepted
mem_rd_addr  out  32  read address
mem_rsp_valid  in  1  read data returned, in order, one per request
mem_rsp_data  in  DATA_W  read data
mem_wr_valid  out  1  write request valid
mem_wr_ready  in  1  write accepted
mem_wr_addr  out  32  write address
mem_wr_data  out  DATA_W  write data
buf_wr_en  out  1  buffer write enable
buf_wr_addr  out  BUF_AW  buffer write address
buf_wr_data  out  DATA_W  buffer write data
buf_rd_en  out  1  buffer read enable (1-cycle read latency)
buf_rd_addr  out  BUF_AW  buffer read address
buf_rd_data  in  DATA_W  buffer read data, valid the cycle after buf_rd_en
busy  out  1  engine not IDLE
buffer_loaded  out  1  sticky; drives general__buffer_loaded
buffer_saved  out  1  sticky; drives general__buffer_saved

Behaviour:
- **Reset:** all outputs are 0, state is IDLE, and all counters are 0.
- **State machine:** states are IDLE, LOAD, SAVE_RD, SAVE_WR and DRAIN.
- **IDLE, start_load:** latch the load address, word count and buffer address. Clear buffer_loaded. Go to LOAD, or set buffer_loaded next cycle if words==0.
- **IDLE, start_save:** handled the same way using the save fields and buffer_saved, going to SAVE_RD.
- **Simultaneous start_load and start_save:** load wins and save is dropped.
- **Starts while busy:** ignored.
- **LOAD, request side:**
  - mem_rd_valid=1 while issued<words and outstanding<MAX_OUTST.
  - On a valid&ready handshake, the address increments by ADDR_INC (wraps mod 2^32), issued increments and outstanding increments.
- **LOAD, response side:**
  - Each mem_rsp_valid writes buf_wr_en=1 in the same cycle (combinational from the registered address).
  - buf_wr_data=mem_rsp_data. The buffer address increments and wraps mod 2^BUF_AW.
  - received increments and outstanding decrements.
  - A simultaneous request handshake and response leaves outstanding unchanged.
- **LOAD completion:** when received==words, go to IDLE and set buffer_loaded on the same edge.
- **SAVE_RD:** pulse buf_rd_en with the current buffer address, then go to SAVE_WR.
- **SAVE_WR, capture:** on the entry cycle, capture buf_rd_data into the write-data register and assert mem_wr_valid.
- **SAVE_WR, hold:** hold mem_wr_valid, mem_wr_addr and mem_wr_data stable until mem_wr_ready.
- **SAVE_WR, handshake:** increment both addresses and the sent count. If sent==words go to IDLE and set buffer_saved; otherwise go to SAVE_RD.
- **abort:**
  - Valid in any non-IDLE state.
  - Next cycle: drop mem_rd_valid, mem_wr_valid and buf_rd_en.
  - If outstanding>0, go to DRAIN; otherwise go to IDLE.
  - No done flag is set by an abort.
- **DRAIN:** responses decrement outstanding and are discarded (buf_wr_en stays 0). Go to IDLE when outstanding==0.
- **abort in IDLE:** no effect.
- **Counters:** 32-bit. A word count of 0xFFFF_FFFF must complete without overflow.
- **Reset mid-transfer:** immediate return to reset values. Late responses arriving after reset are ignored (the engine is in IDLE).
- **mem_rsp_valid in IDLE:** ignored.

Test Plan:
1. **Basic load:** load_mem_start=0x0000_1000, words=8, buf_addr=0x0020, ready always 1, rsp 2 cycles after request → 8 buffer writes at 0x20..0x27 with the returned data, read addresses 0x1000..0x1007, buffer_loaded=1 after the last write, busy=0.
2. **Read backpressure:** mem_rd_ready held low for 10 cycles, MAX_OUTST=4, responses delayed 20 cycles → never more than 4 outstanding, mem_rd_addr stable while stalled, all 16 words are written.
3. **Save with write stalls:** save 5 words from buf 0xFFFE to mem 0x2000, mem_wr_ready toggling → buffer addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001, 0x0002 (wrap), write data equals buffer contents, buffer_saved=1.
4. **Abort mid-load:** abort after 3 of 10 responses with 4 outstanding → no further requests, 4 late responses produce no buffer writes, busy drops after the last one, buffer_loaded stays 0.
5. **Zero words and start collision:** start_load with words=0 → buffer_loaded=1 in one cycle with no memory traffic. start_load and start_save in the same cycle → only load runs, buffer_saved unchanged.
6. **Async reset during save:** assert rst while mem_wr_valid=1 → all outputs are 0 immediately without a clock edge. A subsequent start_save runs normally.

Source files
------------

// File: rtl/buf_xfer_engine.sv
// Word mover between external memory and the on-chip buffer.
// Loads use pipelined reads with a bounded number of outstanding requests; saves run one word at a time.
module buf_xfer_engine #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BUF_AW    = 16,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned ADDR_INC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              start_save,
  input  logic              abort,
  input  logic [31:0]       load_mem_start,
  input  logic [31:0]       load_words,
  input  logic [15:0]       load_buf_addr,
  input  logic [31:0]       save_mem_start,
  input  logic [31:0]       save_words,
  input  logic [15:0]       save_buf_addr,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  output logic [31:0]       mem_rd_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [31:0]       mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              buf_wr_en,
  output logic [BUF_AW-1:0] buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data,
  output logic              buf_rd_en,
  output logic [BUF_AW-1:0] buf_rd_addr,
  input  logic [DATA_W-1:0] buf_rd_data,
  output logic              busy,
  output logic              buffer_loaded,
  output logic              buffer_saved
);

  localparam int unsigned OutW = $clog2(MAX_OUTST + 1);
  localparam logic [OutW-1:0] OutMax = OutW'(MAX_OUTST);
  localparam logic [31:0] AddrInc = 32'(ADDR_INC);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSaveRd,
    StSaveWr,
    StDrain
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         words_q, words_d;
  logic [BUF_AW-1:0]   buf_addr_q, buf_addr_d;
  logic [31:0]         issued_q, issued_d;
  logic [31:0]         received_q, received_d;
  logic [31:0]         sent_q, sent_d;
  logic [OutW-1:0]     outst_q, outst_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                wr_first_q, wr_first_d;
  logic                loaded_q, loaded_d;
  logic                saved_q, saved_d;

  logic                rd_req;
  logic                rd_hs;
  logic                rsp_take;
  logic                rsp_store;
  logic                wr_req;
  logic                wr_hs;
  logic [DATA_W-1:0]   wr_word;

  assign rd_req    = (state_q == StLoad) && (issued_q < words_q) && (outst_q < OutMax);
  assign rd_hs     = rd_req && mem_rd_ready;
  // Responses only count while something is in flight; strays in IDLE are ignored.
  assign rsp_take  = ((state_q == StLoad) || (state_q == StDrain)) && mem_rsp_valid &&
                     (outst_q != '0);
  assign rsp_store = rsp_take && (state_q == StLoad);
  assign wr_req    = (state_q == StSaveWr);
  assign wr_hs     = wr_req && mem_wr_ready;
  // Buffer data is only valid on the entry cycle; afterwards the captured copy is held.
  assign wr_word   = wr_first_q ? buf_rd_data : wr_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      words_q    <= '0;
      buf_addr_q <= '0;
      issued_q   <= '0;
      received_q <= '0;
      sent_q     <= '0;
      outst_q    <= '0;
      wr_data_q  <= '0;
      wr_first_q <= 1'b0;
      loaded_q   <= 1'b0;
      saved_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      buf_addr_q <= buf_addr_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      sent_q     <= sent_d;
      outst_q    <= outst_d;
      wr_data_q  <= wr_data_d;
      wr_first_q <= wr_first_d;
      loaded_q   <= loaded_d;
      saved_q    <= saved_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    words_d    = words_q;
    buf_addr_d = buf_addr_q;
    issued_d   = issued_q;
    received_d = received_q;
    sent_d     = sent_q;
    outst_d    = outst_q;
    wr_data_d  = wr_data_q;
    wr_first_d = 1'b0;
    loaded_d   = loaded_q;
    saved_d    = saved_q;

    if (rd_hs) begin
      addr_d   = addr_q + AddrInc;
      issued_d = issued_q + 32'd1;
    end

    unique case ({rd_hs, rsp_take})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase

    if (rsp_store) begin
      buf_addr_d = buf_addr_q + 1'b1;
      received_d = received_q + 32'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_load) begin
          addr_d     = load_mem_start;
          words_d    = load_words;
          buf_addr_d = BUF_AW'(load_buf_addr);
          issued_d   = '0;
          received_d = '0;
          outst_d    = '0;
          loaded_d   = (load_words == 32'd0);
          if (load_words != 32'd0) state_d = StLoad;
        end else if (start_save) begin
          addr_d     = save_mem_start;
          words_d    = save_words;
          buf_addr_d = BUF_AW'(save_buf_addr);
          sent_d     = '0;
          saved_d    = (save_words == 32'd0);
          if (save_words != 32'd0) state_d = StSaveRd;
        end
      end

      StLoad: begin
        if (abort) begin
          state_d = (outst_d != '0) ? StDrain : StIdle;
        end else if (received_d == words_q) begin
          state_d  = StIdle;
          loaded_d = 1'b1;
        end
      end

      StSaveRd: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          state_d    = StSaveWr;
          wr_first_d = 1'b1;
        end
      end

      StSaveWr: begin
        if (wr_first_q) wr_data_d = buf_rd_data;
        if (abort) begin
          state_d = StIdle;
        end else if (wr_hs) begin
          addr_d     = addr_q + AddrInc;
          buf_addr_d = buf_addr_q + 1'b1;
          sent_d     = sent_q + 32'd1;
          if (sent_d == words_q) begin
            state_d = StIdle;
            saved_d = 1'b1;
          end else begin
            state_d = StSaveRd;
          end
        end
      end

      StDrain: begin
        if (outst_d == '0) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign mem_rd_valid  = rd_req;
  assign mem_rd_addr   = addr_q;
  assign mem_wr_valid  = wr_req;
  assign mem_wr_addr   = addr_q;
  assign mem_wr_data   = wr_req ? wr_word : '0;
  assign buf_wr_en     = rsp_store;
  assign buf_wr_addr   = buf_addr_q;
  assign buf_wr_data   = rsp_store ? mem_rsp_data : '0;
  assign buf_rd_en     = (state_q == StSaveRd);
  assign buf_rd_addr   = buf_addr_q;
  assign busy          = (state_q != StIdle);
  assign buffer_loaded = loaded_q;
  assign buffer_saved  = saved_q;

endmodule
